// File: rtl/mod47_pkg.sv
// Shared constants and state type for the base-47 digit decoder and its helpers.
package mod47_pkg;

    localparam int MODULUS          = 47;
    localparam int DIGIT_W          = 6;
    localparam int X_W              = 500;
    localparam int EXT_W            = 506;
    // 47^90 < 2^500 < 47^91, so 90 digits is the longest word that can never wrap.
    localparam int MAX_EXACT_DIGITS = 90;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mul47_add.sv
// Combinational t = acc*47 + d, with the multiply built from shifts and adds.
// Purely combinational; no handshake.
module mul47_add
    import mod47_pkg::*;
(
    input  logic [X_W:1]     acc,
    input  logic [DIGIT_W:1] d,
    output logic [EXT_W:1]   t
);

    logic [EXT_W:1] a;

    assign a = EXT_W'(acc);
    // 47 = 32 + 8 + 4 + 2 + 1; the six extra bits hold the full carry-out.
    assign t = (a << 5) + (a << 3) + (a << 2) + (a << 1) + a + EXT_W'(d);

endmodule

// File: rtl/base47_to_bin_500.sv
// Horner-accumulates MS-first base-47 digits into a 500-bit value; result one cycle after the last digit.
// Stalls digits (digit_ready=0) while a finished word waits for X_ready.
module base47_to_bin_500
    import mod47_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [DIGIT_W:1]   digit,
    input  logic               digit_last,
    output logic               X_valid,
    input  logic               X_ready,
    output logic [X_W:1]       X,
    output logic               ovf,
    output logic               digit_err
);

    state_t            state;
    state_t            state_nxt;
    logic [X_W:1]      acc;
    logic              ovf_r;
    logic              err_r;
    logic [EXT_W:1]    t;
    logic              take;
    logic              digit_bad;

    mul47_add u_mul47_add (
        .acc (acc),
        .d   (digit),
        .t   (t)
    );

    assign take      = digit_valid & digit_ready;
    assign digit_bad = (digit >= DIGIT_W'(MODULUS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = digit_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (take && digit_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (X_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        digit_ready = 1'b1;
        X_valid     = 1'b0;
        if (state == DONE) begin
            digit_ready = 1'b0;
            X_valid     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if (take) begin
            if (state == IDLE) begin
                acc   <= X_W'(digit);
                ovf_r <= 1'b0;
                err_r <= digit_bad;
            end else begin
                // Bits above the 500-bit window mean the true value no longer fits.
                acc   <= t[X_W:1];
                ovf_r <= ovf_r | (t[EXT_W:X_W+1] != '0);
                err_r <= err_r | digit_bad;
            end
        end else if (state == DONE && X_ready) begin
            acc   <= '0;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end
    end

    assign X         = acc;
    assign ovf       = ovf_r;
    assign digit_err = err_r;

endmodule
